// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with wrap/stop modes, wrap pulse and cascadable rco.
// Optional compare output enabled by defining COUNTER_UPDOWN_MOD_MATCH_EN.
module counter_updown_mod #(
  parameter int N      = 4,
  parameter int MODULO = 2**N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] din,
  input  logic         enp,
  input  logic         ent,
  input  logic         up,
  input  logic         mode,
`ifdef COUNTER_UPDOWN_MOD_MATCH_EN
  input  logic [N-1:0] cmp,
  output logic         match,
`endif
  output logic [N-1:0] dout,
  output logic         rco,
  output logic         wrap,
  output logic         halted
);

  localparam logic [N-1:0] MAX_VAL = N'(MODULO - 1);

  logic [N-1:0] dout_q, dout_d;
  logic         wrap_q, wrap_d;
  logic         halted_q, halted_d;
  logic [N-1:0] term_s;
  logic         at_term_s;
  logic         cnt_en_s;

  assign term_s    = up ? MAX_VAL : {N{1'b0}};
  assign at_term_s = (dout_q == term_s);
  assign cnt_en_s  = enp & ent & ~halted_q;

  // Next-state: load beats count beats hold; terminal handling depends on mode.
  always_comb begin
    dout_d   = dout_q;
    wrap_d   = 1'b0;
    halted_d = halted_q;
    if (!ld) begin
      dout_d   = (din > MAX_VAL) ? MAX_VAL : din;
      halted_d = 1'b0;
    end else if (cnt_en_s) begin
      if (!at_term_s) begin
        dout_d = up ? (dout_q + N'(1)) : (dout_q - N'(1));
      end else if (!mode) begin
        dout_d = up ? {N{1'b0}} : MAX_VAL;
        wrap_d = 1'b1;
      end else begin
        halted_d = 1'b1;
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // State registers, cleared asynchronously by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dout_q   <= {N{1'b0}};
      wrap_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      wrap_q   <= wrap_d;
      halted_q <= halted_d;
    end
  end

`ifdef COUNTER_UPDOWN_MOD_MATCH_EN
  logic match_q, match_d;

  assign match_d = (dout_d == cmp);

  // Match tracks the value dout takes at this edge, so both update together.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

  // rco ignores enp so a cascade stage sees carry even while the chain is paused.
  assign rco    = ent & at_term_s & ~halted_q;
  assign dout   = dout_q;
  assign wrap   = wrap_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: modulo-10 instance plus a two-stage modulo-16 cascade.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b1, enp = 1'b1, ent = 1'b1, up = 1'b1, mode = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] dout;
  logic       rco, wrap, halted;

  logic       cas_enp = 1'b0;
  logic [3:0] dout0, dout1;
  logic       rco0, rco1, wrap0, wrap1, halted0, halted1;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [3:0] dn_dout [4] = '{4'd2, 4'd1, 4'd0, 4'd9};
  logic       dn_wrap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       dn_rco  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

`ifdef COUNTER_UPDOWN_MOD_MATCH_EN
  logic [3:0] cmp = 4'd5;
  logic       match, match0, match1;
`endif

  always #5 clk = ~clk;

  counter_updown_mod #(.N(4), .MODULO(10)) u_dut (
    .clk(clk), .clr(clr), .ld(ld), .din(din), .enp(enp), .ent(ent),
    .up(up), .mode(mode),
`ifdef COUNTER_UPDOWN_MOD_MATCH_EN
    .cmp(cmp), .match(match),
`endif
    .dout(dout), .rco(rco), .wrap(wrap), .halted(halted)
  );

  counter_updown_mod #(.N(4), .MODULO(16)) u_c0 (
    .clk(clk), .clr(clr), .ld(1'b1), .din(4'd0), .enp(cas_enp), .ent(1'b1),
    .up(1'b1), .mode(1'b0),
`ifdef COUNTER_UPDOWN_MOD_MATCH_EN
    .cmp(4'd0), .match(match0),
`endif
    .dout(dout0), .rco(rco0), .wrap(wrap0), .halted(halted0)
  );

  counter_updown_mod #(.N(4), .MODULO(16)) u_c1 (
    .clk(clk), .clr(clr), .ld(1'b1), .din(4'd0), .enp(cas_enp), .ent(rco0),
    .up(1'b1), .mode(1'b0),
`ifdef COUNTER_UPDOWN_MOD_MATCH_EN
    .cmp(4'd0), .match(match1),
`endif
    .dout(dout1), .rco(rco1), .wrap(wrap1), .halted(halted1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held from time 0
    #12;
    check_val("rst_dout", 32'(dout), 32'd0);
    check_val("rst_wrap", 32'(wrap), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_rco", 32'(rco), 32'd0);
    clr = 1'b1;

    // up count wrapping 0..9,0
    for (int i = 1; i <= 10; i++) begin
      step();
      check_val("up_dout", 32'(dout), 32'(i % 10));
      check_val("up_wrap", 32'(wrap), (i == 10) ? 32'd1 : 32'd0);
      check_val("up_rco", 32'(rco), ((i % 10) == 9) ? 32'd1 : 32'd0);
    end

    // down count from a load of 3
    up = 1'b0; ld = 1'b0; din = 4'd3;
    step();
    check_val("dn_load", 32'(dout), 32'd3);
    check_val("dn_load_wrap", 32'(wrap), 32'd0);
    ld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("dn_dout", 32'(dout), 32'(dn_dout[i]));
      check_val("dn_wrap", 32'(wrap), 32'(dn_wrap[i]));
      check_val("dn_rco", 32'(rco), 32'(dn_rco[i]));
    end

    // stop-at-terminal mode
    mode = 1'b1; up = 1'b1; ld = 1'b0; din = 4'd8;
    step();
    check_val("stop_load", 32'(dout), 32'd8);
    ld = 1'b1;
    step();
    check_val("stop_d9", 32'(dout), 32'd9);
    check_val("stop_h0", 32'(halted), 32'd0);
    check_val("stop_rco1", 32'(rco), 32'd1);
    step();
    check_val("stop_hold", 32'(dout), 32'd9);
    check_val("stop_h1", 32'(halted), 32'd1);
    check_val("stop_rco0", 32'(rco), 32'd0);
    check_val("stop_wrap", 32'(wrap), 32'd0);
    up = 1'b0;
    step();
    check_val("stop_flip_dout", 32'(dout), 32'd9);
    check_val("stop_flip_h", 32'(halted), 32'd1);
    up = 1'b1; ld = 1'b0; din = 4'd2;
    step();
    check_val("stop_reload", 32'(dout), 32'd2);
    check_val("stop_reload_h", 32'(halted), 32'd0);
    ld = 1'b1;
    step();
    check_val("resume3", 32'(dout), 32'd3);
    step();
    check_val("resume4", 32'(dout), 32'd4);

    // direction flip while sitting at the up-terminal counts down normally
    mode = 1'b0; ld = 1'b0; din = 4'd9;
    step();
    up = 1'b0; ld = 1'b1;
    step();
    check_val("flip_dout", 32'(dout), 32'd8);
    check_val("flip_wrap", 32'(wrap), 32'd0);

    // out-of-range load clamps, then asynchronous clear mid-cycle
    up = 1'b1; mode = 1'b1; ld = 1'b0; din = 4'd12;
    step();
    check_val("clamp", 32'(dout), 32'd9);
    ld = 1'b1;
    step();
    check_val("clamp_halt", 32'(halted), 32'd1);
    #3 clr = 1'b0;
    #1;
    check_val("aclr_dout", 32'(dout), 32'd0);
    check_val("aclr_halted", 32'(halted), 32'd0);
    check_val("aclr_wrap", 32'(wrap), 32'd0);
    #1 clr = 1'b1;

    // two-stage cascade
    cas_enp = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_val("cas_d0_15", 32'(dout0), 32'd15);
    check_val("cas_d1_0", 32'(dout1), 32'd0);
    check_val("cas_rco0", 32'(rco0), 32'd1);
    cas_enp = 1'b0;
    step();
    check_val("cas_hold_d0", 32'(dout0), 32'd15);
    check_val("cas_hold_d1", 32'(dout1), 32'd0);
    check_val("cas_hold_rco0", 32'(rco0), 32'd1);
    cas_enp = 1'b1;
    step();
    check_val("cas_d0_0", 32'(dout0), 32'd0);
    check_val("cas_d1_1", 32'(dout1), 32'd1);
    check_val("cas_rco0_0", 32'(rco0), 32'd0);
    check_val("cas_wrap0", 32'(wrap0), 32'd1);
    check_val("cas_wrap1", 32'(wrap1), 32'd0);
    check_val("cas_rco1", 32'(rco1), 32'd0);
    check_val("cas_halted", 32'({halted0, halted1}), 32'd0);
    cas_enp = 1'b0;

`ifdef COUNTER_UPDOWN_MOD_MATCH_EN
    check_val("cas_match0", 32'(match0), 32'd1);
    check_val("cas_match1", 32'(match1), 32'd0);
    mode = 1'b0; up = 1'b1; ld = 1'b0; din = 4'd0;
    step();
    check_val("match_load", 32'(match), 32'd0);
    ld = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_val("match_dout", 32'(dout), 32'(i));
      check_val("match", 32'(match), (i == 5) ? 32'd1 : 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
